// File: rtl/i_exp_sequencer.sv
// Integer-only exp sequencer for one softmax element: range reduction by iterative
// subtraction, second-order polynomial on the remainder, then arithmetic shift by z.
module i_exp_sequencer #(
  parameter int BITS_CHOICE = 0,
  parameter int ZMAX        = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] in_q,
  input  logic signed [31:0] cfg_q_ln2,
  input  logic signed [31:0] cfg_q_b,
  input  logic signed [31:0] cfg_q_c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] out_q,
  output logic [5:0]         out_z,
  output logic               out_underflow,
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_REDUCE, S_POLY, S_DONE} state_t;

  localparam logic [5:0] ZMAX_Z = 6'(ZMAX);

  state_t             state_q, state_d;
  logic [32:0]        r_q, r_d;
  logic [5:0]         z_q, z_d;
  logic signed [31:0] p_q, p_d;
  logic               uf_q, uf_d;
  logic signed [31:0] ln2_q, ln2_d;
  logic signed [31:0] b_q, b_d;
  logic signed [31:0] c_q, c_d;
  logic signed [31:0] res_q, res_d;
  logic [5:0]         zo_q, zo_d;
  logic               ufo_q, ufo_d;

  logic               r_ge;
  logic signed [31:0] sum;
  logic signed [63:0] prod;
  logic signed [31:0] poly;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      z_q     <= '0;
      p_q     <= '0;
      uf_q    <= 1'b0;
      ln2_q   <= '0;
      b_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
      zo_q    <= '0;
      ufo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      z_q     <= z_d;
      p_q     <= p_d;
      uf_q    <= uf_d;
      ln2_q   <= ln2_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
      zo_q    <= zo_d;
      ufo_q   <= ufo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    z_d     = z_q;
    p_d     = p_q;
    uf_d    = uf_q;
    ln2_d   = ln2_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    zo_d    = zo_q;
    ufo_d   = ufo_q;

    // r is kept 33 bits wide so that -(-2^31) stays positive
    r_ge = $signed({1'b0, r_q}) >= $signed({{2{ln2_q[31]}}, ln2_q});
    sum  = p_q + b_q;
    prod = sum * p_q;
    poly = 32'(prod >>> BITS_CHOICE) + c_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ln2_d   = cfg_q_ln2;
          b_d     = cfg_q_b;
          c_d     = cfg_q_c;
          r_d     = (in_q > 0) ? 33'd0 : 33'd0 - {in_q[31], in_q};
          z_d     = '0;
          state_d = S_REDUCE;
        end
      end
      S_REDUCE: begin
        if (r_ge && (z_q < ZMAX_Z)) begin
          r_d = 33'(r_q - {{1{ln2_q[31]}}, ln2_q});
          z_d = z_q + 6'd1;
        end else begin
          p_d     = 32'd0 - r_q[31:0];
          uf_d    = r_ge;
          state_d = S_POLY;
        end
      end
      S_POLY: begin
        res_d   = uf_q ? 32'sd0 : (poly >>> z_q);
        zo_d    = z_q;
        ufo_d   = uf_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready      = (state_q == S_IDLE);
  assign out_valid     = (state_q == S_DONE);
  assign busy          = (state_q != S_IDLE);
  assign out_q         = res_q;
  assign out_z         = zo_q;
  assign out_underflow = ufo_q;

endmodule
